// File: rtl/minsoc_spi_boot_pkg.sv
// Shared types and constants for the SPI flash boot loader.
package minsoc_spi_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_SIZE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DATA  = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } boot_state_e;

  localparam logic [7:0]  SPI_READ_CMD = 8'h03;
  localparam logic [31:0] HDR_BYTES    = 32'd4;

  // Bits to fetch for the next word: a full word, or only the bytes left in the image.
  function automatic logic [5:0] word_bits(input logic [31:0] remaining);
    logic [5:0] bits;
    if (remaining >= HDR_BYTES) begin
      bits = 6'd32;
    end else begin
      bits = {1'b0, remaining[1:0], 3'b000};
    end
    return bits;
  endfunction

endpackage

// File: rtl/minsoc_spi_boot_shifter.sv
// SPI mode-0 engine: sclk divider, 32-bit shift register and bit counter.
// A transfer runs from start_i until nbits have been sampled, then pulses done_o and idles with sclk low.
module minsoc_spi_boot_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] load_i,
  input  logic [5:0]  nbits_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic [31:0] rx_o,
  output logic        done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active_q, active_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [31:0]      sh_q, sh_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [5:0]       nbits_q, nbits_d;
  logic             done_q, done_d;

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= {DIV_W{1'b0}};
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      sh_q     <= 32'd0;
      cnt_q    <= 6'd0;
      nbits_q  <= 6'd32;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      nbits_q  <= nbits_d;
      done_q   <= done_d;
    end
  end

  // Rising sclk samples MISO; falling sclk presents the next MOSI bit.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    nbits_d  = nbits_q;
    done_d   = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      div_d    = {DIV_W{1'b0}};
      sclk_d   = 1'b0;
      mosi_d   = load_i[31];
      sh_d     = load_i;
      cnt_d    = 6'd0;
      nbits_d  = nbits_i;
    end else if (active_q) begin
      if (div_q == DIV_LAST) begin
        div_d = {DIV_W{1'b0}};
        if (!sclk_q) begin
          sclk_d = 1'b1;
          sh_d   = {sh_q[30:0], miso_i};
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q + 6'd1 == nbits_q) begin
            active_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            active_d = 1'b1;
          end
        end else begin
          sclk_d = 1'b0;
          mosi_d = sh_q[31];
        end
      end else begin
        div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      // Paused between transfers: clock parked low, MOSI quiet.
      div_d  = {DIV_W{1'b0}};
      sclk_d = 1'b0;
      mosi_d = 1'b0;
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign done_o = done_q;
  assign rx_o   = sh_q << (6'd32 - nbits_q);

endmodule

// File: rtl/minsoc_spi_boot.sv
// Copies a length-prefixed image from SPI flash into RAM, then releases the CPU.
// Optional size validation is enabled by defining SPI_BOOT_LENGTH_CHECK_EN.
module minsoc_spi_boot
  import minsoc_spi_boot_pkg::*;
#(
  parameter int          CLK_DIV     = 2,
  parameter int          ADR_WIDTH   = 13,
  parameter logic [23:0] FLASH_START = 24'h000000
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [1:0]           spi_ss,
  output logic                 mem_we,
  output logic [ADR_WIDTH-1:0] mem_adr,
  output logic [31:0]          mem_dat,
  input  logic                 mem_ack,
  output logic                 cpu_rst,
  output logic                 boot_done,
  output logic                 boot_err
);

  boot_state_e          state_q, state_d;
  logic                 ss_q, ss_d;
  logic [31:0]          rem_q, rem_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADR_WIDTH-1:0] mem_adr_q, mem_adr_d;
  logic [31:0]          mem_dat_q, mem_dat_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 start_s;
  logic [31:0]          load_s;
  logic [5:0]           nbits_s;
  logic [31:0]          rx_s;
  logic                 done_s;
  logic [31:0]          rem_next_s;
  logic                 size_bad_s;

  minsoc_spi_boot_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (start_s),
    .load_i  (load_s),
    .nbits_i (nbits_s),
    .miso_i  (spi_miso),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi),
    .rx_o    (rx_s),
    .done_o  (done_s)
  );

  assign rem_next_s = rem_q - HDR_BYTES;

`ifdef SPI_BOOT_LENGTH_CHECK_EN
  localparam logic [32:0] MAX_BYTES = 33'd4 << ADR_WIDTH;
  assign size_bad_s = (rem_q < HDR_BYTES) || (rem_q[1:0] != 2'b00) ||
                      ({1'b0, rem_q} > MAX_BYTES);
`else
  assign size_bad_s = 1'b0;
`endif

  // Boot FSM and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ss_q      <= 1'b1;
      rem_q     <= 32'd0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= {ADR_WIDTH{1'b0}};
      mem_dat_q <= 32'd0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_q      <= ss_d;
      rem_q     <= rem_d;
      mem_we_q  <= mem_we_d;
      mem_adr_q <= mem_adr_d;
      mem_dat_q <= mem_dat_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; rem_q carries the image size until the header word is written.
  always_comb begin
    state_d   = state_q;
    ss_d      = ss_q;
    rem_d     = rem_q;
    mem_we_d  = mem_we_q;
    mem_adr_d = mem_adr_q;
    mem_dat_d = mem_dat_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    start_s   = 1'b0;
    load_s    = 32'd0;
    nbits_s   = 6'd32;
    case (state_q)
      ST_IDLE: begin
        ss_d    = 1'b0;
        start_s = 1'b1;
        load_s  = {SPI_READ_CMD, FLASH_START};
        state_d = ST_CMD;
      end
      ST_CMD: begin
        if (done_s) begin
          start_s = 1'b1;
          state_d = ST_SIZE;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_SIZE: begin
        if (done_s) begin
          rem_d   = rx_s;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SIZE;
        end
      end
      ST_CHECK: begin
        if (size_bad_s) begin
          ss_d    = 1'b1;
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          mem_we_d  = 1'b1;
          mem_dat_d = rem_q;
          state_d   = ST_WRITE;
        end
      end
      ST_DATA: begin
        if (done_s) begin
          mem_we_d  = 1'b1;
          mem_dat_d = rx_s;
          state_d   = ST_WRITE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          mem_we_d  = 1'b0;
          mem_adr_d = mem_adr_q + {{(ADR_WIDTH-1){1'b0}}, 1'b1};
          rem_d     = rem_next_s;
          if (rem_q <= HDR_BYTES) begin
            ss_d      = 1'b1;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            start_s = 1'b1;
            nbits_s = word_bits(rem_next_s);
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        ss_d      = 1'b1;
        cpu_rst_d = 1'b1;
        err_d     = 1'b1;
        state_d   = ST_ERROR;
      end
    endcase
  end

  assign spi_ss    = {1'b1, ss_q};
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_dat   = mem_dat_q;
  assign cpu_rst   = cpu_rst_q;
  assign boot_done = done_q;
  assign boot_err  = err_q;

endmodule

// File: tb/tb_minsoc_spi_boot.sv
// Directed bench for minsoc_spi_boot with a bit-level SPI flash model and RAM ack responder.
module tb_minsoc_spi_boot;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  img [0:31];
  logic [31:0] exp_std [0:3] = '{32'h00000010, 32'h11223344, 32'h55667788, 32'h99AABBCC};
  int n_chk = 0;
  int n_pass = 0;

  function automatic logic img_bit(input int k);
    logic [7:0] b;
    if (k >= 256) return 1'b0;
    b = img[k / 8];
    return b[7 - (k % 8)];
  endfunction

  // Instance 0: CLK_DIV=2, instance 1: CLK_DIV=1; each with its own flash model and RAM responder.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        rst_n, miso, ack;
    logic        sclk, mosi, mem_we, cpu_rst, boot_done, boot_err;
    logic [1:0]  ss;
    logic [12:0] mem_adr;
    logic [31:0] mem_dat;
    int          ack_dly, rise, tot_rise, mosi_bad, sclk_bad, we_cnt, wr_n, wcnt;
    logic        prev;
    logic [31:0] cap;
    logic [12:0] wr_adr [0:15];
    logic [31:0] wr_dat [0:15];

    minsoc_spi_boot #(
      .CLK_DIV     ((g == 0) ? 2 : 1),
      .ADR_WIDTH   (13),
      .FLASH_START (24'h010000)
    ) dut (
      .clk       (clk),
      .reset     (rst_n),
      .spi_sclk  (sclk),
      .spi_mosi  (mosi),
      .spi_miso  (miso),
      .spi_ss    (ss),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_dat   (mem_dat),
      .mem_ack   (ack),
      .cpu_rst   (cpu_rst),
      .boot_done (boot_done),
      .boot_err  (boot_err)
    );

    initial begin
      miso = 1'b0; ack = 1'b0; prev = 1'b0; wcnt = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          miso = 1'b0; ack = 1'b0; wcnt = 0; rise = 0; tot_rise = 0; cap = 32'd0;
          mosi_bad = 0; sclk_bad = 0; we_cnt = 0; wr_n = 0;
        end else begin
          if (ss[0]) begin
            rise = 0;
            miso = 1'b0;
            if (mosi !== 1'b0) mosi_bad++;
          end else begin
            if (sclk && !prev) begin
              if (rise < 32) cap = {cap[30:0], mosi};
              else if (mosi !== 1'b0) mosi_bad++;
              rise++;
              tot_rise++;
            end
            if (!sclk && prev && rise >= 32) miso = img_bit(rise - 32);
          end
          if (mem_we) we_cnt++;
          if (mem_we && sclk) sclk_bad++;
          if (mem_we && !ack) begin
            if (wcnt >= ack_dly) begin
              ack = 1'b1;
              if (wr_n < 16) begin
                wr_adr[wr_n] = mem_adr;
                wr_dat[wr_n] = mem_dat;
              end
              wr_n++;
            end else begin
              wcnt++;
            end
          end else begin
            ack  = 1'b0;
            wcnt = 0;
          end
        end
        prev = sclk;
      end
    end
  end

  task automatic load_image(input logic [159:0] bytes);
    for (int i = 0; i < 32; i++) img[i] = (i < 20) ? bytes[159 - 8*i -: 8] : 8'hEE;
  endtask

  task automatic wait_boot0(input int budget);
    int k;
    k = 0;
    while (!(g_inst[0].boot_done || g_inst[0].boot_err) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(g_inst[0].boot_done || g_inst[0].boot_err)) begin
      n_chk++;
      $display("FAIL boot_timeout0: no done/err within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({g_inst[0].sclk, g_inst[0].mosi, g_inst[0].ss, g_inst[0].mem_we, g_inst[0].cpu_rst,
         g_inst[0].boot_done, g_inst[0].boot_err} !== 8'b0011_0100)
      $display("FAIL reset_ctrl: got %b want 00110100", {g_inst[0].sclk, g_inst[0].mosi,
               g_inst[0].ss, g_inst[0].mem_we, g_inst[0].cpu_rst, g_inst[0].boot_done, g_inst[0].boot_err});
    else n_pass++;
    n_chk++;
    if (g_inst[0].mem_adr !== 13'd0 || g_inst[0].mem_dat !== 32'd0)
      $display("FAIL reset_mem: adr %h dat %h want 0 0", g_inst[0].mem_adr, g_inst[0].mem_dat);
    else n_pass++;
  endtask

  task automatic test_image();
    load_image({128'h00000010_11223344_55667788_99AABBCC, 32'hEEEEEEEE});
    g_inst[0].ack_dly = 0;
    g_inst[0].rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (g_inst[0].ss !== 2'b10 || g_inst[0].sclk !== 1'b0)
      $display("FAIL ss_fall: ss %b sclk %b want 10 0", g_inst[0].ss, g_inst[0].sclk);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (g_inst[0].sclk !== 1'b1) $display("FAIL first_rise: sclk %b want 1", g_inst[0].sclk);
    else n_pass++;
    wait_boot0(3000);
    n_chk++;
    if (g_inst[0].wr_n !== 4) $display("FAIL img_nwr: got %0d want 4", g_inst[0].wr_n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (g_inst[0].wr_adr[i] !== 13'(i) || g_inst[0].wr_dat[i] !== exp_std[i])
        $display("FAIL img_wr%0d: got (%0d,%h) want (%0d,%h)", i, g_inst[0].wr_adr[i],
                 g_inst[0].wr_dat[i], i, exp_std[i]);
      else n_pass++;
    end
    n_chk++;
    if ({g_inst[0].boot_done, g_inst[0].cpu_rst, g_inst[0].ss, g_inst[0].boot_err} !== 5'b10110)
      $display("FAIL img_final: done/rst/ss/err %b want 10110",
               {g_inst[0].boot_done, g_inst[0].cpu_rst, g_inst[0].ss, g_inst[0].boot_err});
    else n_pass++;
    n_chk++;
    if (g_inst[0].cap !== 32'h03010000) $display("FAIL cmd_mosi: got %h want 03010000", g_inst[0].cap);
    else n_pass++;
    n_chk++;
    if (g_inst[0].mosi_bad !== 0) $display("FAIL mosi_idle: %0d nonzero samples want 0", g_inst[0].mosi_bad);
    else n_pass++;
  endtask

  task automatic test_ack_delay();
    g_inst[0].rst_n = 1'b0;
    @(negedge clk);
    g_inst[0].ack_dly = 7;
    @(negedge clk);
    g_inst[0].rst_n = 1'b1;
    wait_boot0(4000);
    n_chk++;
    if (g_inst[0].wr_n !== 4) $display("FAIL dly_nwr: got %0d want 4", g_inst[0].wr_n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (g_inst[0].wr_adr[i] !== 13'(i) || g_inst[0].wr_dat[i] !== exp_std[i])
        $display("FAIL dly_wr%0d: got (%0d,%h) want (%0d,%h)", i, g_inst[0].wr_adr[i],
                 g_inst[0].wr_dat[i], i, exp_std[i]);
      else n_pass++;
    end
    n_chk++;
    if (g_inst[0].sclk_bad !== 0) $display("FAIL dly_sclk_low: %0d high cycles in WRITE want 0", g_inst[0].sclk_bad);
    else n_pass++;
    n_chk++;
    if (g_inst[0].tot_rise !== 160) $display("FAIL dly_rises: got %0d want 160", g_inst[0].tot_rise);
    else n_pass++;
    n_chk++;
    if (g_inst[0].we_cnt !== 32) $display("FAIL dly_we_cycles: got %0d want 32", g_inst[0].we_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    g_inst[0].rst_n = 1'b0;
    @(negedge clk);
    g_inst[0].ack_dly = 0;
    @(negedge clk);
    g_inst[0].rst_n = 1'b1;
    k = 0;
    while (g_inst[0].wr_n < 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (40) @(negedge clk);
    g_inst[0].rst_n = 1'b0;
    #1;
    n_chk++;
    if ({g_inst[0].sclk, g_inst[0].mosi, g_inst[0].ss, g_inst[0].mem_we, g_inst[0].cpu_rst,
         g_inst[0].boot_done, g_inst[0].boot_err} !== 8'b0011_0100 || g_inst[0].mem_adr !== 13'd0 ||
        g_inst[0].mem_dat !== 32'd0)
      $display("FAIL midrst_vals: ctrl %b adr %0d dat %h want 00110100 0 0", {g_inst[0].sclk,
               g_inst[0].mosi, g_inst[0].ss, g_inst[0].mem_we, g_inst[0].cpu_rst,
               g_inst[0].boot_done, g_inst[0].boot_err}, g_inst[0].mem_adr, g_inst[0].mem_dat);
    else n_pass++;
    repeat (3) @(negedge clk);
    g_inst[0].rst_n = 1'b1;
    wait_boot0(3000);
    n_chk++;
    if (g_inst[0].cap !== 32'h03010000) $display("FAIL midrst_cmd: got %h want 03010000", g_inst[0].cap);
    else n_pass++;
    n_chk++;
    if (g_inst[0].wr_n !== 4 || g_inst[0].wr_dat[2] !== 32'h55667788 || g_inst[0].wr_dat[3] !== 32'h99AABBCC ||
        g_inst[0].wr_adr[3] !== 13'd3)
      $display("FAIL midrst_load: n %0d w2 %h w3 (%0d,%h) want 4 55667788 (3,99aabbcc)", g_inst[0].wr_n,
               g_inst[0].wr_dat[2], g_inst[0].wr_adr[3], g_inst[0].wr_dat[3]);
    else n_pass++;
    n_chk++;
    if (g_inst[0].boot_done !== 1'b1 || g_inst[0].cpu_rst !== 1'b0)
      $display("FAIL midrst_done: done %b cpu_rst %b want 1 0", g_inst[0].boot_done, g_inst[0].cpu_rst);
    else n_pass++;
  endtask

  task automatic test_size_check();
    g_inst[0].rst_n = 1'b0;
    load_image(160'h00000012_11223344_55667788_99AABBCC_AABBCCDD);
    repeat (2) @(negedge clk);
    g_inst[0].rst_n = 1'b1;
    wait_boot0(3000);
`ifdef SPI_BOOT_LENGTH_CHECK_EN
    n_chk++;
    if (g_inst[0].boot_err !== 1'b1 || g_inst[0].boot_done !== 1'b0)
      $display("FAIL size_err: err %b done %b want 1 0", g_inst[0].boot_err, g_inst[0].boot_done);
    else n_pass++;
    n_chk++;
    if (g_inst[0].we_cnt !== 0 || g_inst[0].wr_n !== 0)
      $display("FAIL size_nowrite: we cycles %0d writes %0d want 0 0", g_inst[0].we_cnt, g_inst[0].wr_n);
    else n_pass++;
    n_chk++;
    if (g_inst[0].cpu_rst !== 1'b1 || g_inst[0].ss !== 2'b11)
      $display("FAIL size_hold: cpu_rst %b ss %b want 1 11", g_inst[0].cpu_rst, g_inst[0].ss);
    else n_pass++;
`else
    n_chk++;
    if (g_inst[0].wr_n !== 5) $display("FAIL size_nwr: got %0d want 5", g_inst[0].wr_n);
    else n_pass++;
    n_chk++;
    if (g_inst[0].wr_adr[4] !== 13'd4 || g_inst[0].wr_dat[4] !== 32'hAABB0000)
      $display("FAIL size_last: got (%0d,%h) want (4,aabb0000)", g_inst[0].wr_adr[4], g_inst[0].wr_dat[4]);
    else n_pass++;
    n_chk++;
    if (g_inst[0].wr_dat[0] !== 32'h00000012 || g_inst[0].tot_rise !== 176 || g_inst[0].boot_done !== 1'b1)
      $display("FAIL size_seq: hdr %h rises %0d done %b want 00000012 176 1", g_inst[0].wr_dat[0],
               g_inst[0].tot_rise, g_inst[0].boot_done);
    else n_pass++;
`endif
  endtask

  task automatic test_clkdiv1();
    int k;
    g_inst[0].rst_n = 1'b0;
    load_image({32'h00000004, 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE});
    g_inst[1].ack_dly = 0;
    @(negedge clk);
    g_inst[1].rst_n = 1'b1;
    k = 0;
    while (!(g_inst[1].boot_done || g_inst[1].boot_err) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (g_inst[1].boot_done !== 1'b1 || g_inst[1].cpu_rst !== 1'b0)
      $display("FAIL div1_done: done %b cpu_rst %b want 1 0", g_inst[1].boot_done, g_inst[1].cpu_rst);
    else n_pass++;
    n_chk++;
    if (g_inst[1].wr_n !== 1 || g_inst[1].wr_adr[0] !== 13'd0 || g_inst[1].wr_dat[0] !== 32'h00000004)
      $display("FAIL div1_wr: n %0d (%0d,%h) want 1 (0,00000004)", g_inst[1].wr_n,
               g_inst[1].wr_adr[0], g_inst[1].wr_dat[0]);
    else n_pass++;
    n_chk++;
    if (g_inst[1].tot_rise !== 64) $display("FAIL div1_rises: got %0d want 64", g_inst[1].tot_rise);
    else n_pass++;
  endtask

  initial begin
    g_inst[0].rst_n = 1'b0;
    g_inst[1].rst_n = 1'b0;
    g_inst[0].ack_dly = 0;
    g_inst[1].ack_dly = 0;
    load_image(160'd0);
    test_reset();
    test_image();
    test_ack_delay();
    test_reset_mid();
    test_size_check();
    test_clkdiv1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/minsoc_spi_boot.md
# minsoc_spi_boot

Boot loader that copies a length-prefixed firmware image from SPI flash into on-chip RAM after reset, then releases the CPU. It sits between the board SPI flash pins (`spi_flash_*` of minsoc_top) and the on-chip RAM write port, holding the OR1200 in reset until the image is loaded. It is the consumer of the START_UP byte stream: the 4 bytes clocked during the command phase are ignored, then big-endian bytes follow, and the first word is the image size in bytes, header included.

## Interface
- `CLK_DIV`, default 2: clk cycles per sclk half-period; legal range ≥1.
- `ADR_WIDTH`, default 13: RAM word-address width (matches MEMORY_ADR_WIDTH).
- `FLASH_START`, default 24'h000000: flash byte address sent with the READ command.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `spi_sclk` out 1: SPI clock, mode 0 (idle low).
- `spi_mosi` out 1: serial data to flash.
- `spi_miso` in 1: serial data from flash.
- `spi_ss` out 2: chip selects, active low; bit 0 = flash, bit 1 constant 1.
- `mem_we` out 1: write request; held until `mem_ack`.
- `mem_adr` out ADR_WIDTH: RAM word address.
- `mem_dat` out 32: RAM write data, big-endian (first byte in [31:24]).
- `mem_ack` in 1: write accepted this cycle.
- `cpu_rst` out 1: CPU reset, active high.
- `boot_done` out 1: image loaded; sticky until reset.
- `boot_err` out 1: size rejected; sticky until reset.

## Operation
- Reset values: `spi_sclk`=0, `spi_mosi`=0, `spi_ss`=2'b11, `mem_we`=0, `mem_adr`=0, `mem_dat`=0, `cpu_rst`=1, `boot_done`=0, `boot_err`=0.
- FSM states:
  - IDLE: one cycle after reset release. Drives `spi_ss[0]`=0, then goes to CMD.
  - CMD: shifts 32 bits MSB-first on MOSI: 8'h03 followed by FLASH_START. MISO is ignored. Goes to SIZE.
  - SIZE: shifts in 32 bits into the size register. Goes to CHECK.
  - CHECK: one cycle; see Configuration. Goes to WRITE or ERROR.
  - DATA: shifts in 4 bytes, or fewer for the final partial word. Goes to WRITE.
  - WRITE: `mem_we`=1 until `mem_ack`. On ack, `mem_adr` increments and the remaining count decrements by 4. If remaining >0, goes to DATA; otherwise goes to DONE.
  - DONE: `spi_ss`=11, `cpu_rst`=0, `boot_done`=1. Terminal.
  - ERROR: `spi_ss`=11, `cpu_rst`=1, `boot_err`=1. Terminal.
- The header word is itself written to word 0. Remaining count = size−4 after the header write.
- Final partial word (size mod 4 ≠ 0): unread low bytes are zero.
- `mem_adr` wraps modulo 2^ADR_WIDTH.
- Count arithmetic is 32-bit unsigned; remaining ≤4 means last word.
- MOSI is 0 outside CMD.

## Timing
- sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles; one byte takes 16·CLK_DIV clk cycles.
- The first sclk rise occurs CLK_DIV cycles after `spi_ss[0]` falls.
- MISO is sampled on the clk edge that drives `spi_sclk` high, i.e. the value present before the flash updates after the rise.
- MOSI changes on the clk edge that drives sclk low. The first bit is valid when ss falls.
- During WRITE, sclk is frozen low. No bit is lost regardless of `mem_ack` latency.
- `mem_we` rises on the cycle after the 32nd (or last) sampled bit.
- `mem_ack` coincident with the write: the next DATA sclk low phase starts on the following cycle.
- `reset` asserted at any point: all outputs take their reset values immediately. On release, the sequence restarts from IDLE.

## Configuration
- `SPI_BOOT_LENGTH_CHECK_EN` defined: CHECK goes to ERROR, with no RAM write, when size<4, size[1:0]≠0, or size > 4·2^ADR_WIDTH.
- Undefined: CHECK always proceeds to WRITE. Partial final words are zero-padded and addresses wrap.

## Structure
- Package `minsoc_spi_boot_pkg` holds:
  - the FSM state enum;
  - `SPI_READ_CMD` = 8'h03;
  - the header length constant (4).
- Sub-module `minsoc_spi_boot_shifter` provides sclk generation, the CLK_DIV counter, the 32-bit bidirectional shift register, and a bit counter with start/pause/done handshake.

## Test plan
- Flash model returns 16-byte image 00000010 11223344 55667788 99AABBCC (CLK_DIV=2, ack same cycle). Required: writes (0,00000010), (1,11223344), (2,55667788), (3,99AABBCC); then `boot_done`=1, `cpu_rst`=0, `spi_ss`=11.
- Monitor MOSI over the first 32 sclk rises with FLASH_START=24'h010000. Required: 0x03010000; MOSI=0 afterwards.
- `mem_ack` delayed 7 cycles on every write. Required: same RAM contents as scenario 1; sclk low throughout each WRITE; exactly 32·5 sclk rises in total.
- Assert reset during the 2nd data word, then release. Required: outputs take reset values, the command is re-issued, and the image loads correctly.
- size=0x12 with the macro defined. Required: `boot_err`=1, no `mem_we`, `cpu_rst` stays 1. Without the macro: 5 writes, the last being (4, AABB0000) for bytes AA BB.
- CLK_DIV=1 with a 4-byte image (size=4). Required: a single write (0,00000004), and `boot_done` 64 sclk rises after ss falls.
